motor_pid_ctrl: RTL and testbench



---
 rtl/motor_pid_ctrl_if.sv | 12 +
 rtl/motor_pid_ctrl.sv | 87 ++++++++
 tb/tb_motor_pid_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/motor_pid_ctrl_if.sv
// motor_pid_ctrl_if: setpoint/gain/measurement inputs and PWM-facing outputs of the velocity PID
interface motor_pid_ctrl_if #(parameter int DUTY_W = 16);
  logic en;
  logic signed [31:0] rot_v, p_gain, i_gain, d_gain, meas;
  logic meas_valid;
  logic [DUTY_W-1:0] duty;
  logic dir, out_valid, overrun;
  modport master(output en, rot_v, p_gain, i_gain, d_gain, meas, meas_valid,
                 input duty, dir, out_valid, overrun);
  modport slave(input en, rot_v, p_gain, i_gain, d_gain, meas, meas_valid,
                output duty, dir, out_valid, overrun);
endinterface

// File: rtl/motor_pid_ctrl.sv
// motor_pid_ctrl: saturated PID velocity loop sharing one multiplier across P, I and D
module motor_pid_ctrl #(
  parameter int GAIN_FRAC = 8,
  parameter logic [31:0] INTEG_MAX = 32'd1_000_000,
  parameter int DUTY_W = 16,
  parameter int DUTY_MAX = 1000
) (
  input logic clk,
  input logic rst,
  motor_pid_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SAT} state_t;
  localparam logic signed [33:0] IMAX = {2'b00, INTEG_MAX};
  localparam logic [65:0] DMAX = 66'(DUTY_MAX);
  state_t state, state_n;
  logic signed [31:0] rot_r, meas_r, kp, ki, kd, err_r, deriv_r, integ, prev_err;
  logic signed [31:0] err, deriv, integ_new, mul_a, mul_b;
  logic signed [33:0] integ_sum;
  logic signed [63:0] prod;
  logic signed [65:0] acc, u;
  logic [65:0] mag;
  logic start;
  function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
    return (x[32] != x[31]) ? {x[32], {31{~x[32]}}} : x[31:0];
  endfunction
  assign start = bus.en && bus.meas_valid && state == IDLE;
  assign err = sat32({rot_r[31], rot_r} - {meas_r[31], meas_r});
  assign deriv = sat32({err[31], err} - {prev_err[31], prev_err});
  assign integ_sum = {{2{integ[31]}}, integ} + {{2{err[31]}}, err};
  assign integ_new = 32'(integ_sum > IMAX ? IMAX : integ_sum < -IMAX ? -IMAX : integ_sum);
  assign mul_a = state == MUL_P ? kp : state == MUL_I ? ki : kd;
  assign mul_b = state == MUL_P ? err_r : state == MUL_I ? integ : deriv_r;
  assign prod = mul_a * mul_b;
  assign u = acc >>> GAIN_FRAC;
  assign mag = u[65] ? -u : u;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.meas_valid ? ERR : IDLE;
      ERR: state_n = MUL_P;
      MUL_P: state_n = MUL_I;
      MUL_I: state_n = MUL_D;
      MUL_D: state_n = SAT;
      default: state_n = IDLE;
    endcase
    if (!bus.en) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // disable shares the reset values so an abort leaves the loop exactly as after rst
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      integ <= '0;
      prev_err <= '0;
      acc <= '0;
      bus.duty <= '0;
      bus.dir <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.out_valid <= state == SAT;
      bus.overrun <= bus.meas_valid && state != IDLE;
      if (state == ERR) begin
        integ <= integ_new;
        prev_err <= err;
      end
      if (state == MUL_P || state == MUL_I || state == MUL_D)
        acc <= (state == MUL_P ? '0 : acc) + {{2{prod[63]}}, prod};
      if (state == SAT) begin
        bus.dir <= !u[65];
        bus.duty <= mag > DMAX ? DUTY_W'(DUTY_MAX) : DUTY_W'(mag);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (start) begin
      rot_r <= bus.rot_v;
      meas_r <= bus.meas;
      kp <= bus.p_gain;
      ki <= bus.i_gain;
      kd <= bus.d_gain;
    end
    if (state == ERR) begin
      err_r <= err;
      deriv_r <= deriv;
    end
  end
endmodule

// File: tb/tb_motor_pid_ctrl.sv
// tb_motor_pid_ctrl: table-driven vectors with a result scoreboard plus abort/overrun/clamp sequences
module tb_motor_pid_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  motor_pid_ctrl_if #(.DUTY_W(16)) b1();
  motor_pid_ctrl_if #(.DUTY_W(16)) b2();
  motor_pid_ctrl dut (.clk(clk), .rst(rst), .bus(b1.slave));
  motor_pid_ctrl #(.INTEG_MAX(32'd20)) dut_c (.clk(clk), .rst(rst), .bus(b2.slave));
  assign b2.en = b1.en;
  assign b2.rot_v = b1.rot_v;
  assign b2.meas = b1.meas;
  assign b2.p_gain = b1.p_gain;
  assign b2.i_gain = b1.i_gain;
  assign b2.d_gain = b1.d_gain;
  assign b2.meas_valid = b1.meas_valid;

  typedef struct { int clr, rv, m, kp, ki, kd, duty, dir; } vec_t;
  typedef struct { int duty, dir; } exp_t;
  vec_t vecs[16];
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int duty, input int dir);
    exp_t e;
    e.duty = duty;
    e.dir = dir;
    q.push_back(e);
  endtask

  task automatic set_in(input int rv, input int m, input int kp, input int ki, input int kd);
    b1.rot_v = rv;
    b1.meas = m;
    b1.p_gain = kp;
    b1.i_gain = ki;
    b1.d_gain = kd;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b1.out_valid) begin
      if (q.size() == 0) check("unexpected out_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("duty", int'(b1.duty), e.duty);
        check("dir", int'(b1.dir), e.dir);
      end
    end
  end

  // called on a negedge; returns on the negedge where out_valid is seen
  task automatic run_vec(input vec_t v);
    int lat = 0;
    bit ovr = 1'b0;
    set_in(v.rv, v.m, v.kp, v.ki, v.kd);
    b1.meas_valid = 1'b1;
    push(v.duty, v.dir);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      b1.meas_valid = 1'b0;
      if (k == 1) set_in(32'h5A5A5A5A, -7, 999, 999, 999);
      ovr |= b1.overrun;
      if (b1.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 6);
    check("spurious overrun", int'(ovr), 0);
  endtask

  task automatic clear();
    b1.en = 1'b0;
    repeat (2) @(negedge clk);
    check("clear duty", int'(b1.duty), 0);
    check("clear dir", int'(b1.dir), 1);
    b1.en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit saw;
    vecs[0]  = '{1, 123, 7, 0, 0, 0, 0, 1};
    vecs[1]  = '{0, 100, 40, 256, 0, 0, 60, 1};
    vecs[2]  = '{0, 100, 130, 256, 0, 0, 30, 0};
    vecs[3]  = '{1, 10, 0, 0, 128, 0, 5, 1};
    vecs[4]  = '{0, 10, 0, 0, 128, 0, 10, 1};
    vecs[5]  = '{0, 10, 0, 0, 128, 0, 15, 1};
    vecs[6]  = '{1, 50, 0, 0, 0, 256, 50, 1};
    vecs[7]  = '{0, 20, 0, 0, 0, 256, 30, 0};
    vecs[8]  = '{0, 5000, 0, 256, 0, 0, 1000, 1};
    vecs[9]  = '{0, 0, 5000, 256, 0, 0, 1000, 0};
    vecs[10] = '{1, 200, 180, 512, 256, -128, 50, 1};
    vecs[11] = '{0, 0, 3, 100, 0, 0, 2, 0};
    vecs[12] = '{0, 5, 6, 1, 0, 0, 1, 0};
    vecs[13] = '{0, 6, 5, 1, 0, 0, 0, 1};
    vecs[14] = '{0, 32'h7FFFFFFF, 32'h80000000, 1, 0, 0, 1000, 1};
    vecs[15] = '{1, 999, 0, 256, 0, 0, 999, 1};
    b1.en = 1'b1;
    b1.meas_valid = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset duty", int'(b1.duty), 0);
    check("reset dir", int'(b1.dir), 1);
    check("reset out_valid", int'(b1.out_valid), 0);
    check("reset overrun", int'(b1.overrun), 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].clr != 0) clear();
      run_vec(vecs[i]);
    end
    // integrator clamp on the INTEG_MAX = 20 instance
    clear();
    for (int i = 0; i < 5; i++) begin
      v = '{0, 10, 0, 0, 128, 0, 5 * (i + 1), 1};
      run_vec(v);
      check("clamped duty", int'(b2.duty), i == 0 ? 5 : 10);
    end
    // overrun: second strobe sampled at N+3 is dropped
    set_in(100, 40, 256, 0, 0);
    b1.meas_valid = 1'b1;
    push(60, 1);
    @(negedge clk);
    b1.meas_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_in(0, 5000, 256, 0, 0);
    b1.meas_valid = 1'b1;
    check("overrun before", int'(b1.overrun), 0);
    @(negedge clk);
    b1.meas_valid = 1'b0;
    check("overrun pulse", int'(b1.overrun), 1);
    @(negedge clk);
    check("overrun width", int'(b1.overrun), 0);
    check("busy out_valid", int'(b1.out_valid), 0);
    @(negedge clk);
    check("result after overrun", int'(b1.out_valid), 1);
    // enable abort at N+2 clears the integrator
    clear();
    v = '{0, 10, 0, 0, 128, 0, 5, 1};
    run_vec(v);
    set_in(10, 0, 0, 128, 0);
    b1.meas_valid = 1'b1;
    @(negedge clk);
    b1.meas_valid = 1'b0;
    @(negedge clk);
    b1.en = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw |= b1.out_valid;
    end
    check("abort out_valid", int'(saw), 0);
    check("abort duty", int'(b1.duty), 0);
    b1.meas_valid = 1'b1;
    @(negedge clk);
    b1.meas_valid = 1'b0;
    check("disabled overrun", int'(b1.overrun), 0);
    b1.en = 1'b1;
    run_vec(v);
    // reset at N+3 drops the in-flight result
    v = '{0, 100, 40, 256, 0, 0, 60, 1};
    run_vec(v);
    set_in(0, 100, 256, 0, 0);
    b1.meas_valid = 1'b1;
    @(negedge clk);
    b1.meas_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst duty", int'(b1.duty), 0);
    check("rst dir", int'(b1.dir), 1);
    check("rst out_valid", int'(b1.out_valid), 0);
    check("rst overrun", int'(b1.overrun), 0);
    repeat (6) @(negedge clk);
    v = '{0, 10, 0, 0, 128, 0, 5, 1};
    run_vec(v);
    repeat (2) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
